// File: rtl/ifetch_issue_if.sv
// Fetch/issue bus bundle: instruction-memory req/gnt/rvalid, branch redirect, and decode-side valid/ready.
// master = fetch unit, slave = memory/branch/decode side.
interface ifetch_issue_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [31:0]       out_instr;
  logic [5:0]        out_op;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr, out_op,
    input  imem_gnt, imem_rvalid, imem_rdata, redir_valid, redir_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr, out_op,
    output imem_gnt, imem_rvalid, imem_rdata, redir_valid, redir_pc, out_ready
  );
endinterface

// File: rtl/ifetch_issue.sv
// Instruction fetch/issue unit: one outstanding imem request into a DEPTH-entry issue FIFO, flushed by redirects.
// Optional IFETCH_STATS_EN adds stat_issued / stat_flushed counters.
module ifetch_issue #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  ifetch_issue_if.master bus
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]    stat_issued,
  output logic [31:0]    stat_flushed
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic              pend, pend_nxt;
  logic [ADDR_W-1:0] pend_pc, pend_pc_nxt;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] redir_tgt;
  logic              imem_req;
  logic              push, pop, flush;
  logic [CNT_W-1:0]  count, cnt_after;
  logic [PTR_W-1:0]  wptr, rptr;
  logic [ADDR_W-1:0] mem_pc    [DEPTH];
  logic [31:0]       mem_instr [DEPTH];

  assign flush     = bus.redir_valid;
  assign redir_tgt = {bus.redir_pc[ADDR_W-1:2], 2'b00};
  assign pop       = (count != '0) & bus.out_ready & ~flush;
  assign cnt_after = count + CNT_W'(1) - CNT_W'(pop);

  // Next-state: a redirect seen in REQ without gnt is parked in pend_pc so imem_addr stays stable until gnt.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    pend_nxt     = pend;
    pend_pc_nxt  = pend_pc;
    push         = 1'b0;
    imem_req     = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush) begin
          fetch_pc_nxt = redir_tgt;
          state_nxt    = REQ;
        end else if (count < DEPTH_C) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        imem_req = 1'b1;
        if (bus.imem_gnt) begin
          if (flush) begin
            fetch_pc_nxt = redir_tgt;
            pend_nxt     = 1'b0;
            state_nxt    = DROP;
          end else if (pend) begin
            fetch_pc_nxt = pend_pc;
            pend_nxt     = 1'b0;
            state_nxt    = DROP;
          end else begin
            fetch_pc_nxt = fetch_pc + ADDR_W'(4);
            state_nxt    = WAIT;
          end
        end else if (flush) begin
          pend_nxt    = 1'b1;
          pend_pc_nxt = redir_tgt;
        end
      end
      WAIT: begin
        if (flush) begin
          fetch_pc_nxt = redir_tgt;
          state_nxt    = bus.imem_rvalid ? REQ : DROP;
        end else if (bus.imem_rvalid) begin
          push      = 1'b1;
          state_nxt = (cnt_after < DEPTH_C) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (flush) fetch_pc_nxt = redir_tgt;
        if (bus.imem_rvalid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      pend     <= 1'b0;
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      pend     <= pend_nxt;
      if (flush) begin
        count <= '0;
        wptr  <= '0;
        rptr  <= '0;
      end else begin
        if (push) wptr <= wptr + PTR_W'(1);
        if (pop)  rptr <= rptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // FIFO storage and captured request address carry no reset; out_* are gated by out_valid.
  always_ff @(posedge clk) begin
    pend_pc <= pend_pc_nxt;
    if (state == REQ && bus.imem_gnt) req_pc <= fetch_pc;
    if (push) begin
      mem_pc[wptr]    <= req_pc;
      mem_instr[wptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req  = imem_req;
  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = (count != '0);
  assign bus.out_pc    = bus.out_valid ? mem_pc[rptr]    : '0;
  assign bus.out_instr = bus.out_valid ? mem_instr[rptr] : '0;
  assign bus.out_op    = bus.out_instr[31:26];

`ifdef IFETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_issued  <= '0;
      stat_flushed <= '0;
    end else begin
      if (pop)   stat_issued  <= stat_issued + 32'd1;
      if (flush) stat_flushed <= stat_flushed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_issue.sv
// Bench for ifetch_issue: scripted imem responder, table of fetch vectors, scoreboard of issued words.
// A second instance with RESET_PC=0xFFFF_FFFC mirrors the same stimulus to exercise PC wrap.
module tb_ifetch_issue;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ifetch_issue_if #(.ADDR_W(32)) bus ();
  ifetch_issue_if #(.ADDR_W(32)) bus2 ();

  assign bus2.imem_gnt    = bus.imem_gnt;
  assign bus2.imem_rvalid = bus.imem_rvalid;
  assign bus2.imem_rdata  = bus.imem_rdata;
  assign bus2.redir_valid = bus.redir_valid;
  assign bus2.redir_pc    = bus.redir_pc;
  assign bus2.out_ready   = bus.out_ready;

`ifdef IFETCH_STATS_EN
  logic [31:0] s_iss, s_fl, s_iss2, s_fl2;
`endif

  ifetch_issue #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef IFETCH_STATS_EN
    , .stat_issued(s_iss), .stat_flushed(s_fl)
`endif
  );

  ifetch_issue #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
`ifdef IFETCH_STATS_EN
    , .stat_issued(s_iss2), .stat_flushed(s_fl2)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  typedef struct {
    logic [31:0] data;
    int          gdly;
    int          rdly;
    logic [31:0] addr;
    logic [5:0]  op;
  } vec_t;

  sb_t  sbq[$];
  vec_t vecs[4];
  int   checks   = 0;
  int   failures = 0;
  int   n_redir  = 0;
  int   n_iss    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard pop on the falling edge, ahead of the rising edge that completes the handshake.
  task automatic mon();
    sb_t e;
    if (rst_n && bus.out_valid && bus.out_ready && !bus.redir_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual_pc=0x%0h required=no_issue", bus.out_pc);
      end else begin
        e = sbq.pop_front();
        n_iss++;
        chk("sb_pc", bus.out_pc, e.pc);
        chk("sb_instr", bus.out_instr, e.instr);
        chk("sb_op", bus.out_op, e.instr[31:26]);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.redir_valid = 1'b0;
    sbq.delete();
    n_redir = 0;
    n_iss = 0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      step();
      n++;
    end
    ok = bus.imem_req;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL req_timeout actual=no_req required=imem_req_within_20_cycles");
    end
  endtask

  task automatic redirect(input logic [31:0] tgt);
    bus.redir_valid = 1'b1;
    bus.redir_pc = tgt;
    sbq.delete();
    n_redir++;
    step();
    bus.redir_valid = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] data, input int gdly, input int rdly,
                          input logic [31:0] exp_addr, input bit push_sb);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    chk("fetch_addr", bus.imem_addr, exp_addr);
    repeat (gdly) begin
      step();
      chk("req_held", bus.imem_req, 1'b1);
      chk("addr_stable", bus.imem_addr, exp_addr);
    end
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    repeat (rdly) step();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = data;
    if (push_sb) sbq.push_back('{pc: exp_addr, instr: data});
    step();
    bus.imem_rvalid = 1'b0;
  endtask

  initial begin
    bit ok;
    vecs[0] = '{data: 32'h2042_0001, gdly: 1, rdly: 0, addr: 32'h4,  op: 6'h08};
    vecs[1] = '{data: 32'hAC43_0008, gdly: 0, rdly: 2, addr: 32'h8,  op: 6'h2B};
    vecs[2] = '{data: 32'h1000_FFFF, gdly: 2, rdly: 1, addr: 32'hC,  op: 6'h04};
    vecs[3] = '{data: 32'hFC00_0000, gdly: 0, rdly: 0, addr: 32'h10, op: 6'h3F};

    bus.out_ready = 1'b1;
    bus.redir_pc = '0;
    bus.imem_rdata = '0;
    do_reset();

    // Reset state (rst_n just released, registers still at reset values)
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_instr", bus.out_instr, 32'h0);
    chk("rst_op", bus.out_op, 6'h0);
    chk("rst_addr_wrapdut", bus2.imem_addr, 32'hFFFF_FFFC);

    // First fetch, one-cycle issue latency, and the wrap on the second instance
    do_fetch(32'h8C01_0004, 0, 0, 32'h0, 1'b1);
    chk("t1_valid", bus.out_valid, 1'b1);
    chk("t1_pc", bus.out_pc, 32'h0);
    chk("t1_instr", bus.out_instr, 32'h8C01_0004);
    chk("t1_op", bus.out_op, 6'h23);
    chk("t1_next_addr", bus.imem_addr, 32'h4);
    chk("t5_wrap_out_pc", bus2.out_pc, 32'hFFFF_FFFC);
    chk("t5_wrap_addr", bus2.imem_addr, 32'h0);

    for (int i = 0; i < 4; i++) begin
      do_fetch(vecs[i].data, vecs[i].gdly, vecs[i].rdly, vecs[i].addr, 1'b1);
      chk("vec_valid", bus.out_valid, 1'b1);
      chk("vec_pc", bus.out_pc, vecs[i].addr);
      chk("vec_op", bus.out_op, vecs[i].op);
    end
    step();
    chk("vec_sb_empty", sbq.size(), 0);

    // FIFO full with decode stalled: fetch stops at DEPTH entries
    do_reset();
    bus.out_ready = 1'b0;
    do_fetch(32'h0000_0011, 0, 0, 32'h0, 1'b1);
    do_fetch(32'h0400_0022, 0, 1, 32'h4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t2_req_stopped", bus.imem_req, 1'b0);
      chk("t2_head_pc", bus.out_pc, 32'h0);
      step();
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus.imem_rvalid = 1'b0;
    chk("t2_idle_rvalid_ignored", bus.imem_req, 1'b0);
    bus.out_ready = 1'b1;
    do_fetch(32'h0800_0033, 0, 0, 32'h8, 1'b1);
    step();
    chk("t2_sb_empty", sbq.size(), 0);

    // Redirect while WAIT: returned word dropped, FIFO flushed
    do_reset();
    bus.out_ready = 1'b0;
    do_fetch(32'h1111_1111, 0, 0, 32'h0, 1'b1);
    wait_req(ok);
    chk("t3_addr", bus.imem_addr, 32'h4);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    chk("t3_valid_before", bus.out_valid, 1'b1);
    redirect(32'h0000_0102);
    chk("t3_flushed", bus.out_valid, 1'b0);
    chk("t3_drop_noreq", bus.imem_req, 1'b0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h2222_2222;
    step();
    bus.imem_rvalid = 1'b0;
    chk("t3_drop_discard", bus.out_valid, 1'b0);
    bus.out_ready = 1'b1;
    do_fetch(32'h3333_3333, 0, 0, 32'h100, 1'b1);
    chk("t3_issue_pc", bus.out_pc, 32'h100);

    // Redirect while REQ with gnt held low: address stable, granted word dropped
    do_reset();
    wait_req(ok);
    chk("t4_addr0", bus.imem_addr, 32'h0);
    redirect(32'h0000_0200);
    for (int i = 0; i < 2; i++) begin
      chk("t4_req_held", bus.imem_req, 1'b1);
      chk("t4_addr_stable", bus.imem_addr, 32'h0);
      step();
    end
    chk("t4_addr_at_gnt", bus.imem_addr, 32'h0);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    chk("t4_drop_noreq", bus.imem_req, 1'b0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h4444_4444;
    step();
    bus.imem_rvalid = 1'b0;
    chk("t4_drop_discard", bus.out_valid, 1'b0);
    do_fetch(32'h5555_5555, 0, 0, 32'h200, 1'b1);
    chk("t4_issue_pc", bus.out_pc, 32'h200);
    step();
`ifdef IFETCH_STATS_EN
    chk("stat_flushed", s_fl, 32'(n_redir));
    chk("stat_issued", s_iss, 32'(n_iss));
`endif

    // Reset during WAIT, late rvalid in the release cycle is ignored
    do_reset();
    wait_req(ok);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h6666_6666;
    step();
    bus.imem_rvalid = 1'b0;
    chk("t6_late_rvalid_ignored", bus.out_valid, 1'b0);
    do_fetch(32'h7777_7777, 0, 0, 32'h0, 1'b1);
    chk("t6_issue_pc", bus.out_pc, 32'h0);
    step();
    chk("final_sb_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
